// File: rtl/instruction_fetch.sv
// MIPS instruction fetch stage: owns the PC, drives the instruction memory address,
// and registers the returned word into IF/ID with stall/flush/redirect/fault handling.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pc,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [25:0] jump_index,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        fault
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_id_instr_q, if_id_instr_d;
    logic [31:0] if_id_pc4_q, if_id_pc4_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_pc;
    logic [31:0] next_pc;
    logic        redirect;
    logic        next_illegal;

    assign pc_plus4 = pc_q + 32'd4;
    assign jump_pc  = {pc_plus4[31:28], jump_index, 2'b00};
    assign redirect = branch_taken | jump;

    // Branch beats jump: it belongs to the older instruction further down the pipe.
    always_comb begin
        if (branch_taken) begin
            next_pc = branch_target;
        end else if (jump) begin
            next_pc = jump_pc;
        end else if (stall) begin
            next_pc = pc_q;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // A held PC is never re-checked, so a stall on a legal PC can never fault.
    assign next_illegal = (next_pc != pc_q) &&
                          ((next_pc[1:0] != 2'b00) || (next_pc > LAST_PC));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        fault_d       = fault_q;

        case (state_q)
            ST_BOOT: begin
                state_d       = ST_RUN;
                if_id_valid_d = 1'b0;
            end
            ST_RUN: begin
                if (next_illegal) begin
                    state_d       = ST_HALT;
                    fault_d       = 1'b1;
                    if_id_valid_d = 1'b0;
                end else begin
                    pc_d = next_pc;
                    if (redirect || flush) begin
                        if_id_instr_d = 32'h0;
                        if_id_pc4_d   = 32'h0;
                        if_id_valid_d = 1'b0;
                    end else if (!stall) begin
                        if_id_instr_d = instruction;
                        if_id_pc4_d   = pc_plus4;
                        if_id_valid_d = 1'b1;
                    end
                end
            end
            ST_HALT: begin
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'h0;
            if_id_pc4_q   <= 32'h0;
            if_id_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign pc                = pc_q;
    assign if_id_instruction = if_id_instr_q;
    assign if_id_pc_plus4    = if_id_pc4_q;
    assign if_id_valid       = if_id_valid_q;
    assign fault             = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by random
// stall/flush/branch/jump traffic compared against a cycle-level reference model.
module tb_instruction_fetch;

    localparam int IMEM_BYTES = 256;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fault;

    always #20 clk = ~clk;

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc                (pc),
        .instruction       (instruction),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_index        (jump_index),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fault             (fault)
    );

    logic [31:0] mem [0:63];
    assign instruction = mem[pc[7:2]];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: what the fetch stage should present after each edge.
    bit          m_boot;
    bit          m_halt;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;
    bit          m_fault;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_halt  = 1'b0;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_pc4   = 32'h0;
        m_valid = 1'b0;
        m_fault = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] seq;
        logic [31:0] tgt;
        if (m_halt) return;
        if (m_boot) begin
            m_boot = 1'b0;
            return;
        end
        seq = m_pc + 32'd4;
        if (branch_taken)   tgt = branch_target;
        else if (jump)      tgt = {seq[31:28], jump_index, 2'b00};
        else if (stall)     tgt = m_pc;
        else                tgt = seq;
        if (tgt != m_pc && ((tgt % 4) != 0 || tgt > IMEM_BYTES - 4)) begin
            m_halt  = 1'b1;
            m_fault = 1'b1;
            m_valid = 1'b0;
        end else begin
            if (branch_taken || jump || flush) begin
                m_instr = 32'h0;
                m_pc4   = 32'h0;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = mem[m_pc / 4];
                m_pc4   = seq;
                m_valid = 1'b1;
            end
            m_pc = tgt;
        end
    endtask

    task automatic check_all(input string ctx);
        expect_eq({ctx, ".pc"},    pc,                m_pc);
        expect_eq({ctx, ".instr"}, if_id_instruction, m_instr);
        expect_eq({ctx, ".pc4"},   if_id_pc_plus4,    m_pc4);
        expect_eq({ctx, ".valid"}, {31'h0, if_id_valid}, {31'h0, m_valid});
        expect_eq({ctx, ".fault"}, {31'h0, fault},       {31'h0, m_fault});
    endtask

    task automatic step(input string ctx);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(ctx);
    endtask

    task automatic set_in(input bit b, input logic [31:0] bt, input bit j,
                          input logic [25:0] ji, input bit s, input bit f);
        branch_taken  = b;
        branch_target = bt;
        jump          = j;
        jump_index    = ji;
        stall         = s;
        flush         = f;
    endtask

    // Reset is dropped between edges and must take effect without a clock edge.
    task automatic do_reset(input string ctx);
        #7;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all({ctx, ".async"});
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] held_pc;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h2008_0005;
        mem[1] = 32'h2009_0003;
        mem[2] = 32'h0109_5020;
        reset_n = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);

        // Reset and sequential fetch
        do_reset("por");
        step("boot");
        expect_eq("boot_pc", pc, 32'h0);
        step("first");
        expect_eq("first_word", if_id_instruction, 32'h2008_0005);
        expect_eq("first_pc4", if_id_pc_plus4, 32'h4);
        expect_eq("first_pc", pc, 32'h4);
        step("seq");
        expect_eq("seq_pc", pc, 32'h8);

        // Stall at pc=8
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b1, 1'b0);
        step("stall1");
        step("stall2");
        expect_eq("stall_pc", pc, 32'h8);
        expect_eq("stall_word", if_id_instruction, 32'h2009_0003);
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
        step("unstall");
        expect_eq("unstall_pc", pc, 32'hC);
        step("to16");

        // Branch and jump together: branch wins
        set_in(1'b1, 32'h40, 1'b1, 26'h14, 1'b0, 1'b0);
        step("brjmp");
        expect_eq("brjmp_pc", pc, 32'h40);
        expect_eq("brjmp_valid", {31'h0, if_id_valid}, 32'h0);
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
        step("br_tgt");
        expect_eq("br_tgt_word", if_id_instruction, mem[16]);

        // Jump concatenation from pc=0x10
        set_in(1'b1, 32'h10, 1'b0, 26'h0, 1'b0, 1'b0);
        step("to_0x10");
        set_in(1'b0, 32'h0, 1'b1, 26'h14, 1'b0, 1'b0);
        step("jump");
        expect_eq("jump_pc", pc, 32'h50);
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
        step("post_jump");

        // Sequential run off the end of memory
        set_in(1'b1, 32'hF0, 1'b0, 26'h0, 1'b0, 1'b0);
        step("to_f0");
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
        step("f4");
        step("f8");
        step("fc");
        expect_eq("last_pc", pc, 32'd252);
        step("overrun");
        expect_eq("overrun_fault", {31'h0, fault}, 32'h1);
        expect_eq("overrun_pc", pc, 32'd252);
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), {24'h0, 8'($urandom)}, 1'($urandom), 26'($urandom),
                   1'($urandom), 1'($urandom));
            step("halted");
            expect_eq("halted_valid", {31'h0, if_id_valid}, 32'h0);
        end
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);

        // Reset mid-run at pc=0x30
        do_reset("rst1");
        step("boot2");
        for (int i = 0; i < 12; i++) step("run");
        expect_eq("run_pc", pc, 32'h30);
        do_reset("rst_mid");
        expect_eq("mid_pc", pc, 32'h0);
        expect_eq("mid_fault", {31'h0, fault}, 32'h0);
        step("boot3");
        step("refetch");
        expect_eq("refetch_word", if_id_instruction, 32'h2008_0005);

        // Misaligned branch target
        held_pc = pc;
        set_in(1'b1, 32'h22, 1'b0, 26'h0, 1'b0, 1'b0);
        step("misalign");
        expect_eq("misalign_fault", {31'h0, fault}, 32'h1);
        expect_eq("misalign_pc", pc, held_pc);
        set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
        step("misalign_hold");

        // Random traffic
        do_reset("rst_rand");
        for (int c = 0; c < 800; c++) begin
            logic [31:0] bt;
            logic [25:0] ji;
            bt = ($urandom_range(0, 19) == 0) ? $urandom : {22'h0, 8'($urandom_range(0, 63)), 2'b00};
            ji = ($urandom_range(0, 19) == 0) ? 26'($urandom) : 26'($urandom_range(0, 63));
            set_in($urandom_range(0, 11) == 0, bt, $urandom_range(0, 11) == 0, ji,
                   $urandom_range(0, 99) < 15, $urandom_range(0, 9) == 0);
            step("rand");
            if (m_halt && $urandom_range(0, 3) == 0) begin
                set_in(1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 1'b0);
                do_reset("rand_rst");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
